dual_fetch_queue: RTL and testbench

// - Instruction queue between fetch and the dual-issue check; feeds decode slot 0/slot 1.
// - Accepts 1 or 2 instructions per cycle from fetch and presents the two oldest entries.
// - Retires 0, 1 or 2 entries per cycle, driven by the downstream stall and the issue1 decision.
// - Pair-break (issue1=0) keeps the un-issued instruction at the head for the next cycle.

---
 rtl/dual_fetch_queue.sv | 79 +++++++
 tb/tb_dual_fetch_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: circular instruction queue presenting the two oldest entries to the dual-issue decode slots
module dual_fetch_queue #(
   parameter int DEPTH = 8,
   parameter int XLEN = 32,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_cnt2,
   input  logic [XLEN-1:0]  in_instr0,
   input  logic [XLEN-1:0]  in_pc0,
   input  logic [XLEN-1:0]  in_instr1,
   input  logic [XLEN-1:0]  in_pc1,
   output logic             in_ready,
   output logic             slot0_valid,
   output logic [XLEN-1:0]  slot0_instr,
   output logic [XLEN-1:0]  slot0_pc,
   output logic             slot1_valid,
   output logic [XLEN-1:0]  slot1_instr,
   output logic [XLEN-1:0]  slot1_pc,
   input  logic             deq_ready,
   input  logic             issue1,
   output logic [CNT_W-1:0] occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
   logic [XLEN-1:0]  mem_instr [DEPTH];
   logic [XLEN-1:0]  mem_pc [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
   logic             push;
   logic [1:0]       push_n, pop_n;
   // in_ready depends only on registered occupancy; pop counts follow stall and issue verdict
   always_comb begin
      in_ready    = occupancy <= CNT_W'(DEPTH - 2);
      slot0_valid = occupancy >= CNT_W'(1);
      slot1_valid = occupancy >= CNT_W'(2);
      push        = in_valid & in_ready & ~flush;
      push_n      = push ? (in_cnt2 ? 2'd2 : 2'd1) : 2'd0;
      pop_n       = (deq_ready & slot0_valid) ? ((issue1 & slot1_valid) ? 2'd2 : 2'd1) : 2'd0;
      rd_ptr1     = rd_ptr + PTR_W'(1);
      wr_ptr1     = wr_ptr + PTR_W'(1);
   end
   // slot outputs read storage directly; empty slots show a NOP at PC 0
   always_comb begin
      slot0_instr = slot0_valid ? mem_instr[rd_ptr] : NOP;
      slot0_pc    = slot0_valid ? mem_pc[rd_ptr] : '0;
      slot1_instr = slot1_valid ? mem_instr[rd_ptr1] : NOP;
      slot1_pc    = slot1_valid ? mem_pc[rd_ptr1] : '0;
   end
   // storage write; contents need no reset since invalid slots are masked
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= in_instr0;
         mem_pc[wr_ptr]    <= in_pc0;
         if (in_cnt2) begin
            mem_instr[wr_ptr1] <= in_instr1;
            mem_pc[wr_ptr1]    <= in_pc1;
         end
      end
   end
   // pointer and occupancy update; flush drops both the push and the pop of its cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         rd_ptr    <= rd_ptr + PTR_W'(pop_n);
         wr_ptr    <= wr_ptr + PTR_W'(push_n);
         occupancy <= occupancy + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb_dual_fetch_queue: directed self-checking bench for dual_fetch_queue
module tb_dual_fetch_queue;
   logic        clk, rst_n, flush, in_valid, in_cnt2, deq_ready, issue1;
   logic [31:0] in_instr0, in_pc0, in_instr1, in_pc1;
   logic        in_ready, slot0_valid, slot1_valid;
   logic [31:0] slot0_instr, slot0_pc, slot1_instr, slot1_pc;
   logic [3:0]  occupancy;
   int n_cmp = 0;
   int n_err = 0;

   dual_fetch_queue dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_cnt2(in_cnt2),
      .in_instr0(in_instr0), .in_pc0(in_pc0), .in_instr1(in_instr1), .in_pc1(in_pc1),
      .in_ready(in_ready), .slot0_valid(slot0_valid), .slot0_instr(slot0_instr),
      .slot0_pc(slot0_pc), .slot1_valid(slot1_valid), .slot1_instr(slot1_instr),
      .slot1_pc(slot1_pc), .deq_ready(deq_ready), .issue1(issue1), .occupancy(occupancy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input logic [31:0] i0, p0, i1, p1);
      in_valid = 1; in_cnt2 = 1;
      in_instr0 = i0; in_pc0 = p0; in_instr1 = i1; in_pc1 = p1;
      step;
      in_valid = 0; in_cnt2 = 0;
   endtask

   task automatic push1(input logic [31:0] i0, p0);
      in_valid = 1; in_cnt2 = 0;
      in_instr0 = i0; in_pc0 = p0;
      step;
      in_valid = 0;
   endtask

   task automatic do_flush;
      flush = 1;
      step;
      flush = 0;
   endtask

   task automatic test_reset;
      #3;
      n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (slot0_valid !== 1'b0 || slot1_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b%b want 00", slot0_valid, slot1_valid); end
      n_cmp++; if (slot0_instr !== 32'h13 || slot0_pc !== 32'h0) begin n_err++; $display("FAIL reset_nop got %h@%h want 00000013@0", slot0_instr, slot0_pc); end
      #4 rst_n = 1;
      step;
   endtask

   task automatic test_push2;
      push2(32'hAAAA_0001, 32'h0, 32'hBBBB_0002, 32'h4);
      n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL push2_occ got %0d want 2", occupancy); end
      n_cmp++; if (slot0_instr !== 32'hAAAA_0001 || slot0_pc !== 32'h0) begin n_err++; $display("FAIL push2_slot0 got %h@%h want aaaa0001@0", slot0_instr, slot0_pc); end
      n_cmp++; if (slot1_instr !== 32'hBBBB_0002 || slot1_pc !== 32'h4) begin n_err++; $display("FAIL push2_slot1 got %h@%h want bbbb0002@4", slot1_instr, slot1_pc); end
   endtask

   task automatic test_pair_break;
      do_flush;
      push2(32'hA1, 32'h100, 32'hB1, 32'h104);
      push1(32'hC1, 32'h108);
      n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL brk_pre_occ got %0d want 3", occupancy); end
      deq_ready = 1; issue1 = 0;
      step;
      deq_ready = 0;
      n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL brk_occ got %0d want 2", occupancy); end
      n_cmp++; if (slot0_instr !== 32'hB1 || slot0_pc !== 32'h104) begin n_err++; $display("FAIL brk_slot0 got %h@%h want b1@104", slot0_instr, slot0_pc); end
      n_cmp++; if (slot1_instr !== 32'hC1 || slot1_pc !== 32'h108) begin n_err++; $display("FAIL brk_slot1 got %h@%h want c1@108", slot1_instr, slot1_pc); end
   endtask

   task automatic test_back_to_back;
      do_flush;
      push2(32'hA2, 32'h200, 32'hB2, 32'h204);
      deq_ready = 1; issue1 = 1;
      push2(32'hD2, 32'h208, 32'hE2, 32'h20C);
      deq_ready = 0; issue1 = 0;
      n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL b2b_occ got %0d want 2", occupancy); end
      n_cmp++; if (slot0_instr !== 32'hD2 || slot0_pc !== 32'h208) begin n_err++; $display("FAIL b2b_slot0 got %h@%h want d2@208", slot0_instr, slot0_pc); end
      n_cmp++; if (slot1_instr !== 32'hE2 || slot1_pc !== 32'h20C) begin n_err++; $display("FAIL b2b_slot1 got %h@%h want e2@20c", slot1_instr, slot1_pc); end
   endtask

   task automatic test_full;
      do_flush;
      push2(32'h31, 32'h300, 32'h32, 32'h304);
      push2(32'h33, 32'h308, 32'h34, 32'h30C);
      push2(32'h35, 32'h310, 32'h36, 32'h314);
      n_cmp++; if (in_ready !== 1'b1 || occupancy !== 4'd6) begin n_err++; $display("FAIL full6 got rdy=%b occ=%0d want rdy=1 occ=6", in_ready, occupancy); end
      push1(32'h37, 32'h318);
      n_cmp++; if (in_ready !== 1'b0 || occupancy !== 4'd7) begin n_err++; $display("FAIL full7 got rdy=%b occ=%0d want rdy=0 occ=7", in_ready, occupancy); end
      push2(32'hEE, 32'h3F0, 32'hEF, 32'h3F4);
      n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL full_block got occ=%0d want 7", occupancy); end
      deq_ready = 1; issue1 = 0;
      step;
      deq_ready = 0;
      n_cmp++; if (in_ready !== 1'b1 || occupancy !== 4'd6) begin n_err++; $display("FAIL full_pop got rdy=%b occ=%0d want rdy=1 occ=6", in_ready, occupancy); end
      n_cmp++; if (slot0_instr !== 32'h32 || slot1_pc !== 32'h308) begin n_err++; $display("FAIL full_order got %h,%h want 32,308", slot0_instr, slot1_pc); end
   endtask

   task automatic test_wrap;
      int sent = 0, exp_pc = 0, mocc = 0, pop, pushn;
      logic dr, i1;
      do_flush;
      for (int cyc = 0; cyc < 100 && exp_pc < 80; cyc++) begin
         dr = (cyc % 3) != 2;
         i1 = cyc[0];
         n_cmp++; if (slot0_valid !== (mocc >= 1) || in_ready !== (mocc <= 6)) begin n_err++; $display("FAIL wrap_flags cyc=%0d got v=%b r=%b want occ=%0d", cyc, slot0_valid, in_ready, mocc); end
         pop = 0;
         if (dr && mocc >= 1) begin
            pop = (i1 && mocc >= 2) ? 2 : 1;
            n_cmp++; if (slot0_pc !== exp_pc || slot0_instr !== 32'h8000_0000 + exp_pc) begin n_err++; $display("FAIL wrap_slot0 got %h@%h want pc %h", slot0_instr, slot0_pc, exp_pc); end
            if (pop == 2) begin
               n_cmp++; if (slot1_pc !== exp_pc + 4) begin n_err++; $display("FAIL wrap_slot1 got pc %h want %h", slot1_pc, exp_pc + 4); end
            end
         end
         pushn = (mocc <= 6 && sent < 20) ? 2 : 0;
         in_valid = pushn != 0; in_cnt2 = 1;
         in_pc0 = sent * 4; in_instr0 = 32'h8000_0000 + sent * 4;
         in_pc1 = sent * 4 + 4; in_instr1 = 32'h8000_0000 + sent * 4 + 4;
         deq_ready = dr; issue1 = i1;
         step;
         mocc = mocc + pushn - pop;
         exp_pc = exp_pc + 4 * pop;
         sent = sent + pushn;
      end
      in_valid = 0; in_cnt2 = 0; deq_ready = 0; issue1 = 0;
      n_cmp++; if (exp_pc != 80 || occupancy !== 4'd0) begin n_err++; $display("FAIL wrap_done got drained_pc=%0d occ=%0d want 80,0", exp_pc, occupancy); end
   endtask

   task automatic test_flush;
      do_flush;
      push2(32'h51, 32'h500, 32'h52, 32'h504);
      push2(32'h53, 32'h508, 32'h54, 32'h50C);
      push1(32'h55, 32'h510);
      n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL flush_pre got occ=%0d want 5", occupancy); end
      flush = 1; deq_ready = 1; issue1 = 1;
      push2(32'h56, 32'h514, 32'h57, 32'h518);
      flush = 0;
      n_cmp++; if (occupancy !== 4'd0 || slot0_valid !== 1'b0) begin n_err++; $display("FAIL flush got occ=%0d v=%b want 0,0", occupancy, slot0_valid); end
      step;
      deq_ready = 0; issue1 = 0;
      n_cmp++; if (occupancy !== 4'd0 || slot0_instr !== 32'h13) begin n_err++; $display("FAIL empty_pop got occ=%0d instr=%h want 0,00000013", occupancy, slot0_instr); end
   endtask

   task automatic test_async_reset;
      push2(32'h61, 32'h600, 32'h62, 32'h604);
      n_cmp++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL arst_pre got occ=%0d want 2", occupancy); end
      #1 rst_n = 0;
      #1;
      n_cmp++; if (occupancy !== 4'd0 || slot0_valid !== 1'b0 || slot1_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst got occ=%0d v=%b%b r=%b want 0,00,1", occupancy, slot0_valid, slot1_valid, in_ready); end
      #2 rst_n = 1;
      step;
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; in_cnt2 = 0; deq_ready = 0; issue1 = 0;
      in_instr0 = 0; in_pc0 = 0; in_instr1 = 0; in_pc1 = 0;
      test_reset;
      test_push2;
      test_pair_break;
      test_back_to_back;
      test_full;
      test_wrap;
      test_flush;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
